// File: rtl/usb_pkg.sv
// Shared USB definitions: PID codes, PID group helpers, handshake codes,
// field widths and the receive-buffer FSM state type.
package usb_pkg;

  localparam int PID_W      = 4;
  localparam int DEV_ADDR_W = 7;
  localparam int ENDP_W     = 4;
  localparam int BYTE_W     = 8;

  typedef enum logic [3:0] {
    PID_RSVD  = 4'h0,
    PID_OUT   = 4'h1,
    PID_ACK   = 4'h2,
    PID_DATA0 = 4'h3,
    PID_PING  = 4'h4,
    PID_SOF   = 4'h5,
    PID_NYET  = 4'h6,
    PID_DATA2 = 4'h7,
    PID_SPLIT = 4'h8,
    PID_IN    = 4'h9,
    PID_NAK   = 4'hA,
    PID_DATA1 = 4'hB,
    PID_PRE   = 4'hC,
    PID_SETUP = 4'hD,
    PID_STALL = 4'hE,
    PID_MDATA = 4'hF
  } pid_e;

  // Handshake codes requested from the transmit side
  typedef enum logic [3:0] {
    HS_ACK   = 4'h2,
    HS_NAK   = 4'hA,
    HS_STALL = 4'hE
  } hs_code_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_AWAIT = 2'd1,
    ST_RECV  = 2'd2
  } rx_state_e;

  function automatic logic is_token(input logic [PID_W-1:0] pid);
    case (pid)
      PID_OUT, PID_IN, PID_SOF, PID_SETUP: is_token = 1'b1;
      default:                             is_token = 1'b0;
    endcase
  endfunction

  function automatic logic is_data(input logic [PID_W-1:0] pid);
    case (pid)
      PID_DATA0, PID_DATA1, PID_DATA2, PID_MDATA: is_data = 1'b1;
      default:                                    is_data = 1'b0;
    endcase
  endfunction

  // Only DATA0/DATA1 carry payload for a full-speed OUT/SETUP transfer
  function automatic logic is_data01(input logic [PID_W-1:0] pid);
    case (pid)
      PID_DATA0, PID_DATA1: is_data01 = 1'b1;
      default:              is_data01 = 1'b0;
    endcase
  endfunction

  // Tokens that open a host-to-device data stage
  function automatic logic is_out_or_setup(input logic [PID_W-1:0] pid);
    case (pid)
      PID_OUT, PID_SETUP: is_out_or_setup = 1'b1;
      default:            is_out_or_setup = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/usb_pkt_ram.sv
// Packet payload store: one write port, one registered read port.
// Array contents are not reset; only the read register is.
module usb_pkt_ram #(
  parameter int WORDS  = 66,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              srst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data
);

  logic [7:0] mem [WORDS];

  // Write port
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read port, cleared by either reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= 8'h00;
    end else if (srst) begin
      rd_data <= 8'h00;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/usb_rx_data_buffer.sv
// Receive data buffer: pairs OUT/SETUP tokens for this device with the
// following DATA0/DATA1 packet, stores the payload (CRC16 stripped from the
// reported length), commits only good packets and requests ACK/NAK.
module usb_rx_data_buffer
  import usb_pkg::*;
#(
  parameter  int DEPTH         = 64,
  parameter  int TOKEN_TIMEOUT = 1024,
  localparam int LEN_W         = $clog2(DEPTH + 1)
) (
  input  logic                  clk48,
  input  logic                  reset_n,
  input  logic                  bus_reset,
  input  logic [DEV_ADDR_W-1:0] dev_addr,
  input  logic [BYTE_W-1:0]     byte_in,
  input  logic                  byte_in_valid,
  input  logic [PID_W-1:0]      pid_in,
  input  logic                  pid_valid,
  input  logic [DEV_ADDR_W-1:0] tok_addr,
  input  logic [ENDP_W-1:0]     tok_endp,
  input  logic                  packet_eop,
  input  logic                  packet_good,
  output logic [BYTE_W-1:0]     rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  rx_full,
  output logic [LEN_W-1:0]      rx_len,
  output logic [ENDP_W-1:0]     rx_endp,
  output logic                  rx_setup,
  output logic                  rx_data1,
  input  logic                  rx_release,
  output logic                  hs_ack,
  output logic                  hs_nak
);

  localparam int WORDS  = DEPTH + 2;
  localparam int ADDR_W = $clog2(WORDS);
  localparam int PTR_W  = $clog2(WORDS + 1);
  localparam int CNT_W  = $clog2(TOKEN_TIMEOUT);

  localparam logic [PTR_W-1:0] PTR_FULL = PTR_W'(WORDS);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TOKEN_TIMEOUT - 1);

  rx_state_e         state_r;
  logic [PTR_W-1:0]  wr_ptr_r;
  logic              ovf_r;
  logic [CNT_W-1:0]  tmo_cnt_r;
  logic [ENDP_W-1:0] pend_endp_r;
  logic              pend_setup_r;
  logic              hs_ack_r;
  logic              hs_nak_r;
  logic              rx_full_r;
  logic [LEN_W-1:0]  rx_len_r;
  logic [ENDP_W-1:0] rx_endp_r;
  logic              rx_setup_r;
  logic              rx_data1_r;
  logic [LEN_W-1:0]  rd_ptr_r;
  logic              rd_valid_r;

  logic              in_pkt_s;
  logic [PTR_W-1:0]  base_s;
  logic              ovf_old_s;
  logic              take_s;
  logic              wr_en_s;
  logic              ovf_hit_s;
  logic [PTR_W-1:0]  ptr_eff_s;
  logic              ovf_eff_s;
  logic              eval_s;
  logic              nak_s;
  logic              commit_s;
  logic [LEN_W-1:0]  commit_len_s;
  logic              tok_hit_s;

  logic              rd_adv_s;
  logic              release_s;
  logic              full_n_s;
  logic [LEN_W-1:0]  len_n_s;
  logic [LEN_W-1:0]  rd_ptr_n_s;
  logic              rd_valid_n_s;
  logic              rd_en_s;

  // pid_valid is already folded into packet_good by the decoder
  logic              unused_s;
  assign unused_s = pid_valid;

  // Write-side decode: where the incoming byte lands and how the packet ends
  always_comb begin
    in_pkt_s = (state_r == ST_AWAIT) || (state_r == ST_RECV);
    if (state_r == ST_RECV) begin
      base_s    = wr_ptr_r;
      ovf_old_s = ovf_r;
    end else begin
      base_s    = '0;
      ovf_old_s = 1'b0;
    end
    take_s    = byte_in_valid && in_pkt_s && !rx_full_r;
    wr_en_s   = take_s && (base_s < PTR_FULL);
    ovf_hit_s = take_s && (base_s == PTR_FULL);
    if (wr_en_s) begin
      ptr_eff_s = base_s + PTR_W'(1);
    end else begin
      ptr_eff_s = base_s;
    end
    ovf_eff_s = ovf_old_s || ovf_hit_s;
    eval_s    = packet_eop && packet_good && is_data01(pid_in) && in_pkt_s;
    nak_s     = eval_s && rx_full_r;
    commit_s  = eval_s && !rx_full_r && !ovf_eff_s && (ptr_eff_s != PTR_W'(1));
    if (ptr_eff_s >= PTR_W'(2)) begin
      commit_len_s = LEN_W'(ptr_eff_s - PTR_W'(2));
    end else begin
      commit_len_s = '0;
    end
    tok_hit_s = packet_eop && packet_good && is_out_or_setup(pid_in) &&
                (tok_addr == dev_addr);
  end

  // Read-side next state; the RAM is addressed with the next pointer so the
  // registered byte lines up with rd_valid and drains without bubbles
  always_comb begin
    rd_adv_s  = rd_valid_r && rd_ready;
    release_s = rx_release && rx_full_r;
    if (commit_s) begin
      full_n_s   = 1'b1;
      len_n_s    = commit_len_s;
      rd_ptr_n_s = '0;
    end else if (release_s) begin
      full_n_s   = 1'b0;
      len_n_s    = rx_len_r;
      rd_ptr_n_s = '0;
    end else if (rd_adv_s) begin
      full_n_s   = rx_full_r;
      len_n_s    = rx_len_r;
      rd_ptr_n_s = rd_ptr_r + LEN_W'(1);
    end else begin
      full_n_s   = rx_full_r;
      len_n_s    = rx_len_r;
      rd_ptr_n_s = rd_ptr_r;
    end
    rd_valid_n_s = full_n_s && (rd_ptr_n_s < len_n_s);
    rd_en_s      = commit_s || rd_adv_s;
  end

  // Token association, packet capture, timeout and handshake requests
  always_ff @(posedge clk48 or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      wr_ptr_r     <= '0;
      ovf_r        <= 1'b0;
      tmo_cnt_r    <= '0;
      pend_endp_r  <= '0;
      pend_setup_r <= 1'b0;
      hs_ack_r     <= 1'b0;
      hs_nak_r     <= 1'b0;
    end else if (bus_reset) begin
      state_r      <= ST_IDLE;
      wr_ptr_r     <= '0;
      ovf_r        <= 1'b0;
      tmo_cnt_r    <= '0;
      pend_endp_r  <= '0;
      pend_setup_r <= 1'b0;
      hs_ack_r     <= 1'b0;
      hs_nak_r     <= 1'b0;
    end else begin
      hs_ack_r <= commit_s;
      hs_nak_r <= nak_s;
      case (state_r)
        ST_IDLE: begin
          if (tok_hit_s) begin
            state_r      <= ST_AWAIT;
            pend_endp_r  <= tok_endp;
            pend_setup_r <= (pid_in == PID_SETUP);
            tmo_cnt_r    <= '0;
          end
        end
        ST_AWAIT: begin
          if (packet_eop) begin
            if (eval_s) begin
              state_r <= ST_IDLE;
            end else if (tok_hit_s) begin
              pend_endp_r  <= tok_endp;
              pend_setup_r <= (pid_in == PID_SETUP);
              tmo_cnt_r    <= '0;
            end else begin
              state_r <= ST_IDLE;
            end
          end else if (byte_in_valid) begin
            state_r  <= ST_RECV;
            wr_ptr_r <= ptr_eff_s;
            ovf_r    <= 1'b0;
          end else if (tmo_cnt_r == TMO_LAST) begin
            state_r <= ST_IDLE;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + CNT_W'(1);
          end
        end
        ST_RECV: begin
          if (packet_eop) begin
            state_r <= ST_IDLE;
          end else begin
            wr_ptr_r <= ptr_eff_s;
            if (ovf_hit_s) begin
              ovf_r <= 1'b1;
            end
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Committed-packet descriptor and read pointer
  always_ff @(posedge clk48 or negedge reset_n) begin
    if (!reset_n) begin
      rx_full_r  <= 1'b0;
      rx_len_r   <= '0;
      rx_endp_r  <= '0;
      rx_setup_r <= 1'b0;
      rx_data1_r <= 1'b0;
      rd_ptr_r   <= '0;
      rd_valid_r <= 1'b0;
    end else if (bus_reset) begin
      rx_full_r  <= 1'b0;
      rx_len_r   <= '0;
      rx_endp_r  <= '0;
      rx_setup_r <= 1'b0;
      rx_data1_r <= 1'b0;
      rd_ptr_r   <= '0;
      rd_valid_r <= 1'b0;
    end else begin
      rx_full_r  <= full_n_s;
      rx_len_r   <= len_n_s;
      rd_ptr_r   <= rd_ptr_n_s;
      rd_valid_r <= rd_valid_n_s;
      if (commit_s) begin
        rx_endp_r  <= pend_endp_r;
        rx_setup_r <= pend_setup_r;
        rx_data1_r <= (pid_in == PID_DATA1);
      end
    end
  end

  usb_pkt_ram #(
    .WORDS  (WORDS),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk48),
    .rst_n   (reset_n),
    .srst    (bus_reset),
    .wr_en   (wr_en_s),
    .wr_addr (ADDR_W'(base_s)),
    .wr_data (byte_in),
    .rd_en   (rd_en_s),
    .rd_addr (ADDR_W'(rd_ptr_n_s)),
    .rd_data (rd_data)
  );

  assign rd_valid = rd_valid_r;
  assign rx_full  = rx_full_r;
  assign rx_len   = rx_len_r;
  assign rx_endp  = rx_endp_r;
  assign rx_setup = rx_setup_r;
  assign rx_data1 = rx_data1_r;
  assign hs_ack   = hs_ack_r;
  assign hs_nak   = hs_nak_r;

endmodule
